// File: rtl/pll_dpll_core.sv
// Bang-bang all-digital PLL: sign phase detector, PI loop filter, NCO and windowed lock detector.
// Optional: define PLL_DPLL_INTEG_SAT_EN to saturate the loop integrator instead of letting it wrap.
module pll_dpll_core #(
    parameter int IW            = 8,
    parameter int PW            = 16,
    parameter int KP_SHIFT      = 6,
    parameter int KI_SHIFT      = 2,
    parameter int LOCK_WIN_LOG2 = 6,
    parameter int LOCK_THRESH   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ce,
    input  logic signed [IW-1:0] i_data,
    input  logic        [PW-1:0] i_freq,
    output logic                 o_valid,
    output logic        [PW-1:0] o_phase,
    output logic                 o_ref,
    output logic        [1:0]    o_err,
    output logic                 o_lock
);

    localparam int SW = LOCK_WIN_LOG2 + 2;
    localparam logic        [PW-1:0] KI_STEP     = PW'(1) << KI_SHIFT;
    localparam logic        [PW-1:0] KP_STEP     = PW'(1) << KP_SHIFT;
    localparam logic signed [IW-1:0] ZERO_SAMPLE = '0;
    localparam logic        [SW-1:0] THRESH_W    = SW'(LOCK_THRESH);
`ifdef PLL_DPLL_INTEG_SAT_EN
    localparam logic [PW-1:0] INTEG_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] INTEG_MIN = {1'b1, {(PW-1){1'b0}}};
`endif

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t r_state;
    lock_state_t w_stateNext;

    logic        [PW-1:0]            r_phase;
    logic        [PW-1:0]            r_integ;
    logic        [1:0]               r_err;
    logic                            r_valid;
    logic        [LOCK_WIN_LOG2-1:0] r_winCnt;
    logic signed [SW-1:0]            r_winSum;

    logic                 w_dataNeg;
    logic                 w_ePos;
    logic [PW-1:0]        w_integStep;
    logic [PW-1:0]        w_integNext;
    logic [PW-1:0]        w_prop;
    logic [PW-1:0]        w_freq;
    logic [PW-1:0]        w_phaseNext;
    logic signed [SW-1:0] w_eExt;
    logic signed [SW-1:0] w_sumNext;
    logic [SW-1:0]        w_sumAbs;
    logic                 w_winLast;
    logic                 w_inThresh;

    // Phase detector: +1 when the input sign disagrees with the reference half-cycle.
    assign w_dataNeg = (i_data < ZERO_SAMPLE);
    assign w_ePos    = (w_dataNeg != r_phase[PW-1]);

    always_comb begin
        w_integStep = w_ePos ? (r_integ + KI_STEP) : (r_integ - KI_STEP);
        w_integNext = w_integStep;
`ifdef PLL_DPLL_INTEG_SAT_EN
        // A step can only overflow across the sign boundary, so the sign flip marks saturation.
        if (w_ePos && !r_integ[PW-1] && w_integStep[PW-1]) begin
            w_integNext = INTEG_MAX;
        end else if (!w_ePos && r_integ[PW-1] && !w_integStep[PW-1]) begin
            w_integNext = INTEG_MIN;
        end
`endif
    end

    assign w_prop      = w_ePos ? KP_STEP : ('0 - KP_STEP);
    assign w_freq      = i_freq + w_integNext + w_prop;
    assign w_phaseNext = r_phase + w_freq;

    assign w_eExt     = w_ePos ? SW'(1) : {SW{1'b1}};
    assign w_sumNext  = r_winSum + w_eExt;
    assign w_sumAbs   = w_sumNext[SW-1] ? (-w_sumNext) : w_sumNext;
    assign w_winLast  = &r_winCnt;
    assign w_inThresh = (w_sumAbs <= THRESH_W);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase  <= '0;
            r_integ  <= '0;
            r_err    <= '0;
            r_valid  <= 1'b0;
            r_winCnt <= '0;
            r_winSum <= '0;
        end else begin
            r_valid <= i_ce;
            if (i_ce) begin
                r_phase  <= w_phaseNext;
                r_integ  <= w_integNext;
                r_err    <= w_ePos ? 2'b01 : 2'b11;
                r_winCnt <= r_winCnt + 1'b1;
                r_winSum <= w_winLast ? '0 : w_sumNext;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= UNLOCKED;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Lock decision is taken only on the sample that closes a window.
    always_comb begin
        w_stateNext = r_state;
        if (i_ce && w_winLast) begin
            w_stateNext = w_inThresh ? LOCKED : UNLOCKED;
        end
    end

    assign o_valid = r_valid;
    assign o_phase = r_phase;
    assign o_ref   = r_phase[PW-1];
    assign o_err   = r_err;
    assign o_lock  = (r_state == LOCKED);

endmodule

// File: tb/tb_pll_dpll_core.sv
// Self-checking bench for pll_dpll_core against an arithmetic reference model of the loop.
// Honours PLL_DPLL_INTEG_SAT_EN in the model so both integrator behaviours are checked.
module tb_pll_dpll_core;

    localparam int KP     = 64;
    localparam int KI     = 4;
    localparam int WIN    = 64;
    localparam int THRESH = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ce = 1'b0;
    logic signed [7:0] din = '0;
    logic [15:0]       freq = '0;

    logic        o_valid;
    logic [15:0] o_phase;
    logic        o_ref;
    logic [1:0]  o_err;
    logic        o_lock;

    int total = 0;
    int bad = 0;

    int         mPhase = 0;
    int         mInteg = 0;
    int         mSum = 0;
    int         mCnt = 0;
    int         nSamples = 0;
    logic       mValid = 1'b0;
    logic       mLock = 1'b0;
    logic [1:0] mErr = 2'b00;

    pll_dpll_core dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_ce    (ce),
        .i_data  (din),
        .i_freq  (freq),
        .o_valid (o_valid),
        .o_phase (o_phase),
        .o_ref   (o_ref),
        .o_err   (o_err),
        .o_lock  (o_lock)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] expVec();
        logic [15:0] p;
        p = 16'(mPhase);
        return {mValid, p[15], mErr, mLock, p};
    endfunction

    // Advance the model by the rules of the loop, then clock the DUT and settle.
    task automatic tick();
        int e;
        int nx;
        if (rst) begin
            mPhase = 0; mInteg = 0; mSum = 0; mCnt = 0; nSamples = 0;
            mValid = 1'b0; mLock = 1'b0; mErr = 2'b00;
        end else if (ce) begin
            e = ((din < 0) == (mPhase >= 32768)) ? -1 : 1;
            nx = mInteg + KI * e;
`ifdef PLL_DPLL_INTEG_SAT_EN
            if (nx > 32767) nx = 32767;
            if (nx < -32768) nx = -32768;
`else
            if (nx > 32767) nx = nx - 65536;
            else if (nx < -32768) nx = nx + 65536;
`endif
            mInteg = nx;
            mPhase = (((mPhase + int'(freq) + mInteg + KP * e) % 65536) + 65536) % 65536;
            mErr = (e > 0) ? 2'b01 : 2'b11;
            mValid = 1'b1;
            mSum = mSum + e;
            mCnt = mCnt + 1;
            nSamples = nSamples + 1;
            if (mCnt == WIN) begin
                mLock = (mSum <= THRESH) && (mSum >= -THRESH);
                mSum = 0;
                mCnt = 0;
            end
        end else begin
            mValid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; din = 8'sd55; freq = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({o_valid, o_phase, o_ref, o_err, o_lock} !== 21'd0) begin
                bad++;
                $display("[TB] FAIL reset_hold: got %h required 0", {o_valid, o_phase, o_ref, o_err, o_lock});
            end
        end
        rst = 1'b0; ce = 1'b0;
        tick();
        total++;
        if ({o_valid, o_phase, o_ref, o_err, o_lock} !== 21'd0) begin
            bad++;
            $display("[TB] FAIL reset_release: got %h required 0", {o_valid, o_phase, o_ref, o_err, o_lock});
        end
    endtask

    task automatic test_idle_hold();
        freq = 16'h1000; ce = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            total++;
            if (o_phase !== 16'd0 || o_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL idle_hold: phase=%h valid=%b required phase=0 valid=0", o_phase, o_valid);
            end
        end
    endtask

    task automatic test_first_step();
        rst = 1'b1; ce = 1'b0; tick(); rst = 1'b0;
        freq = 16'h0100; din = 8'sh7F; ce = 1'b1;
        tick();
        ce = 1'b0;
        total++;
        if (o_valid !== 1'b1 || o_err !== 2'b11 || o_phase !== 16'd188) begin
            bad++;
            $display("[TB] FAIL first_step: valid=%b err=%b phase=%0d required 1/11/188", o_valid, o_err, o_phase);
        end
        tick();
        total++;
        if (o_valid !== 1'b0 || o_phase !== 16'd188 || o_err !== 2'b11) begin
            bad++;
            $display("[TB] FAIL first_step_hold: valid=%b err=%b phase=%0d required 0/11/188", o_valid, o_err, o_phase);
        end
    endtask

    // Input sign is steered against o_ref so every sample gives e=+1 and the integrator ramps.
    task automatic test_integ_limit();
        logic [15:0] prevPhase;
        logic [15:0] obsInteg;
        logic [15:0] expInteg;
        int raw;
        rst = 1'b1; ce = 1'b0; tick(); rst = 1'b0;
        freq = 16'h0000; ce = 1'b1;
        for (int k = 1; k <= 8200; k++) begin
            din = o_phase[15] ? 8'sd100 : -8'sd100;
            prevPhase = o_phase;
            tick();
            total++;
            if ({o_valid, o_ref, o_err, o_lock, o_phase} !== expVec()) begin
                bad++;
                $display("[TB] FAIL integ_model k=%0d: got %h required %h", k, {o_valid, o_ref, o_err, o_lock, o_phase}, expVec());
            end
            if (k == 100 || k == 8191 || k == 8192 || k == 8200) begin
                obsInteg = o_phase - prevPhase - 16'd64;
                raw = 4 * k;
`ifdef PLL_DPLL_INTEG_SAT_EN
                expInteg = (raw > 32767) ? 16'h7FFF : 16'(raw);
`else
                expInteg = 16'(raw);
`endif
                total++;
                if (obsInteg !== expInteg || o_err !== 2'b01) begin
                    bad++;
                    $display("[TB] FAIL integ_limit k=%0d: integ=%h err=%b required %h/01", k, obsInteg, o_err, expInteg);
                end
            end
        end
        ce = 1'b0;
    endtask

    task automatic runSquare(input int period, input int samples, input string tag);
        logic prevLock;
        int acq;
        acq = -1;
        prevLock = o_lock;
        ce = 1'b1;
        for (int n = 0; n < samples; n++) begin
            din = ((n % period) < (period / 2)) ? 8'sd100 : -8'sd100;
            tick();
            total++;
            if ({o_valid, o_ref, o_err, o_lock, o_phase} !== expVec()) begin
                bad++;
                $display("[TB] FAIL %s_model n=%0d: got %h required %h", tag, n, {o_valid, o_ref, o_err, o_lock, o_phase}, expVec());
            end
            total++;
            if (o_lock !== prevLock && (nSamples % WIN) != 0) begin
                bad++;
                $display("[TB] FAIL %s_lock_edge n=%0d: lock=%b changed at sample %0d, required window boundary", tag, n, o_lock, nSamples);
            end
            if (acq < 0 && o_lock !== prevLock) acq = n + 1;
            prevLock = o_lock;
        end
        $display("[TB] %s: first lock change after %0d samples, lock now %b", tag, acq, o_lock);
    endtask

    task automatic test_lock();
        rst = 1'b1; ce = 1'b0; tick(); rst = 1'b0;
        freq = 16'h0800;
        runSquare(32, 1024 + 256, "lock32");
        runSquare(20, 256, "period20");
    endtask

    task automatic test_reset_locked();
        runSquare(32, 1024, "prelock");
        $display("[TB] lock before reset = %b", o_lock);
        rst = 1'b1; ce = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (o_lock !== 1'b0 || o_phase !== 16'd0 || o_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_locked: lock=%b phase=%h valid=%b required 0/0/0", o_lock, o_phase, o_valid);
        end
        runSquare(32, 1024, "relock");
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            ce = ($urandom % 4) != 0;
            din = 8'($urandom);
            if ((i % 300) == 0) freq = 16'($urandom);
            rst = (($urandom % 400) == 0);
            tick();
            total++;
            if ({o_valid, o_ref, o_err, o_lock, o_phase} !== expVec()) begin
                bad++;
                $display("[TB] FAIL random i=%0d: got %h required %h", i, {o_valid, o_ref, o_err, o_lock, o_phase}, expVec());
            end
        end
        rst = 1'b0; ce = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_first_step();
        test_integ_limit();
        test_lock();
        test_reset_locked();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
